// File: rtl/timer_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared state encoding and width helpers for the timer arbiter.
//  Revision    : 1.0
// ============================================================================
package timer_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // IDX_W = $clog2(NREQ), floored at 1 so a degenerate count still has a bit
    function automatic int calc_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // PC_W = max(1, $clog2(PRESC)); PRESC=1 keeps a 1-bit counter stuck at 0
    function automatic int calc_pc_w(input int p);
        return (p <= 1) ? 1 : $clog2(p);
    endfunction

    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_arb_if
//  Description : Request/grant/completion bundle between requesters and timer.
//  Revision    : 1.0
// ============================================================================
interface timer_arb_if #(
    parameter int NREQ  = 4,
    parameter int DLY_W = 8
);
    logic                    en;
    logic [NREQ-1:0]         req;
    logic [NREQ*DLY_W-1:0]   dly;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         done;
    logic                    busy;
    logic                    tick;

    modport master (
        output en, req, dly,
        input  gnt, done, busy, tick
    );

    modport slave (
        input  en, req, dly,
        output gnt, done, busy, tick
    );
endinterface
`default_nettype wire

// File: rtl/timer_arb_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Enable-gated prescaler producing a one-cycle tick every PRESC
//                enabled cycles; count is held while en is low.
//  Revision    : 1.0
// ============================================================================
module tick_gen
    import timer_pkg::*;
#(
    parameter int PRESC = 5
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en,
    input  wire logic clr,
    output logic      tick
);
    localparam int                c_PC_W = calc_pc_w(PRESC);
    localparam logic [c_PC_W-1:0] c_LAST = c_PC_W'(PRESC - 1);

    logic [c_PC_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == c_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_PC_W'(1);
            end
        end
    end

    assign tick = en & (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/timer_arb.sv
`default_nettype none
// ============================================================================
//  Module      : timer_arb
//  Description : Round-robin shared countdown timer; grants one requester at a
//                time, counts its delay in prescaled ticks, then pulses done.
//  Revision    : 1.0
// ============================================================================
module timer_arb
    import timer_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DLY_W = 8,
    parameter int PRESC = 5
) (
    input  wire logic   clk,
    input  wire logic   rst,
    timer_arb_if.slave  bus
);
    localparam int c_IDX_W = calc_idx_w(NREQ);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_IDX_W-1:0]   w_next_idx;
    logic [c_IDX_W-1:0]   w_sel_idx;
    logic [c_IDX_W-1:0]   w_cand;
    logic                 w_found;
    logic [DLY_W-1:0]     r_rem;
    logic [DLY_W-1:0]     w_dly_arr [NREQ];
    logic [NREQ-1:0]      w_next_oh;
    logic [NREQ-1:0]      r_gnt;
    logic [NREQ-1:0]      r_done;
    logic                 r_busy;
    logic                 w_tick;
    logic                 w_run_en;
    logic                 w_clr;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_dly_unpack
            assign w_dly_arr[gi] = bus.dly[gi*DLY_W +: DLY_W];
        end
    endgenerate

    // First set request at or after ptr, wrapping explicitly for non-power-of-2 NREQ
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = c_IDX_W'(wrap_add(int'(r_ptr), k, NREQ));
            if (!w_found && bus.req[w_cand]) begin
                w_found   = 1'b1;
                w_sel_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_clr        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_next_state = c_ST_LOAD;
                    w_next_idx   = w_sel_idx;
                end
            end
            c_ST_LOAD: begin
                w_clr        = 1'b1;
                // Zero delay skips RUN so remaining can never underflow
                w_next_state = (w_dly_arr[r_idx] == '0) ? c_ST_DONE : c_ST_RUN;
            end
            c_ST_RUN: begin
                if (w_tick && (r_rem == DLY_W'(1))) begin
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    assign w_run_en  = bus.en & (r_state == c_ST_RUN);
    assign w_next_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_next_idx;

    tick_gen #(
        .PRESC (PRESC)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (w_run_en),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_busy  <= (w_next_state != c_ST_IDLE);
            r_gnt   <= ((w_next_state == c_ST_LOAD) || (w_next_state == c_ST_RUN)) ? w_next_oh : '0;
            r_done  <= (w_next_state == c_ST_DONE) ? w_next_oh : '0;

            if (r_state == c_ST_LOAD) begin
                r_rem <= w_dly_arr[r_idx];
            end else if ((r_state == c_ST_RUN) && w_tick) begin
                r_rem <= r_rem - DLY_W'(1);
            end

            if (r_state == c_ST_DONE) begin
                r_ptr <= (r_idx == c_IDX_W'(NREQ - 1)) ? '0 : (r_idx + c_IDX_W'(1));
            end
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.done = r_done;
    assign bus.busy = r_busy;
    assign bus.tick = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_timer_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_arb
//  Description : Directed self-checking bench; two instances (PRESC=5, PRESC=1)
//                share stimulus, sel1 picks which one is observed.
//  Revision    : 1.0
// ============================================================================
module tb_timer_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [31:0] dly;
    logic        sel1;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    timer_arb_if #(.NREQ(4), .DLY_W(8)) bus5 ();
    timer_arb_if #(.NREQ(4), .DLY_W(8)) bus1 ();

    assign bus5.en  = en;
    assign bus5.req = req;
    assign bus5.dly = dly;
    assign bus1.en  = en;
    assign bus1.req = req;
    assign bus1.dly = dly;

    timer_arb #(.NREQ(4), .DLY_W(8), .PRESC(5)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5.slave)
    );

    timer_arb #(.NREQ(4), .DLY_W(8), .PRESC(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    wire [3:0] m_gnt  = sel1 ? bus1.gnt  : bus5.gnt;
    wire [3:0] m_done = sel1 ? bus1.done : bus5.done;
    wire       m_busy = sel1 ? bus1.busy : bus5.busy;
    wire       m_tick = sel1 ? bus1.tick : bus5.tick;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        dly = 32'd0;
        en  = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        sel1 = 1'b0;
        tests++;
        if ({m_gnt, m_done, m_busy, m_tick} !== 10'd0) begin
            fails++;
            $display("FAIL reset_outputs: gnt=%b done=%b busy=%b tick=%b, expected all zero", m_gnt, m_done, m_busy, m_tick);
        end
        rst = 1'b0;
        step();
        step();
        tests++;
        if (m_busy !== 1'b0 || m_gnt !== 4'b0000) begin
            fails++;
            $display("FAIL reset_idle: busy=%b gnt=%b, expected 0/0000", m_busy, m_gnt);
        end
    endtask

    task automatic test_single();
        int n;
        int ticks;
        sel1 = 1'b0;
        do_reset();
        dly[7:0] = 8'd3;
        req = 4'b0001;
        step();
        n = 1;
        ticks = 0;
        tests++;
        if (m_gnt !== 4'b0001 || m_busy !== 1'b1) begin
            fails++;
            $display("FAIL single_grant: gnt=%b busy=%b, expected 0001/1", m_gnt, m_busy);
        end
        while (m_done === 4'b0000 && n < 40) begin
            if (m_tick) ticks++;
            step();
            n++;
        end
        tests++;
        if (n !== 17 || m_done !== 4'b0001) begin
            fails++;
            $display("FAIL single_done: cycle=%0d done=%b, expected 17/0001", n, m_done);
        end
        tests++;
        if (ticks !== 3) begin
            fails++;
            $display("FAIL single_ticks: ticks=%0d, expected 3", ticks);
        end
        req = 4'b0000;
        step();
        tests++;
        if (m_busy !== 1'b0 || m_gnt !== 4'b0000) begin
            fails++;
            $display("FAIL single_busy_fall: busy=%b gnt=%b at t+18, expected 0/0000", m_busy, m_gnt);
        end
    endtask

    task automatic test_zero_delay();
        logic saw_tick;
        sel1 = 1'b0;
        do_reset();
        dly[23:16] = 8'd0;
        req = 4'b0100;
        saw_tick = m_tick;
        step();
        saw_tick = saw_tick | m_tick;
        tests++;
        if (m_gnt !== 4'b0100) begin
            fails++;
            $display("FAIL zero_grant: gnt=%b, expected 0100", m_gnt);
        end
        step();
        saw_tick = saw_tick | m_tick;
        tests++;
        if (m_done !== 4'b0100 || m_gnt !== 4'b0000) begin
            fails++;
            $display("FAIL zero_done: done=%b gnt=%b at t+2, expected 0100/0000", m_done, m_gnt);
        end
        req = 4'b0000;
        step();
        saw_tick = saw_tick | m_tick;
        tests++;
        if (saw_tick !== 1'b0) begin
            fails++;
            $display("FAIL zero_no_tick: tick seen=%b, expected 0", saw_tick);
        end
    endtask

    task automatic test_round_robin();
        int w;
        logic [3:0] exp_oh;
        sel1 = 1'b1;
        do_reset();
        dly = {4{8'd1}};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            exp_oh = 4'b0001 << (k % 4);
            do begin
                step();
                w++;
            end while (m_done === 4'b0000 && w < 20);
            tests++;
            if (m_done !== exp_oh || w !== ((k == 0) ? 3 : 4)) begin
                fails++;
                $display("FAIL rr_order[%0d]: done=%b after %0d cycles, expected %b after %0d", k, m_done, w, exp_oh, (k == 0) ? 3 : 4);
            end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        int n1;
        sel1 = 1'b0;
        do_reset();
        dly = 32'd0;
        req = 4'b0011;
        n = 0;
        do begin
            step();
            n++;
        end while (m_done === 4'b0000 && n < 20);
        n1 = n;
        tests++;
        if (n1 !== 2 || m_done !== 4'b0001) begin
            fails++;
            $display("FAIL b2b_first: cycle=%0d done=%b, expected 2/0001", n1, m_done);
        end
        do begin
            step();
            n++;
        end while (m_done === 4'b0000 && n < 20);
        tests++;
        if ((n - n1) !== 3 || m_done !== 4'b0010) begin
            fails++;
            $display("FAIL b2b_gap: gap=%0d done=%b, expected 3/0010", n - n1, m_done);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_enable_gating();
        int n;
        int first_tick;
        int ticks;
        logic gap_tick;
        sel1 = 1'b0;
        do_reset();
        dly[7:0] = 8'd2;
        req = 4'b0001;
        n = 0;
        first_tick = -1;
        ticks = 0;
        gap_tick = 1'b0;
        while (m_done === 4'b0000 && n < 60) begin
            if (m_tick) begin
                ticks++;
                if (first_tick < 0) first_tick = n;
                if (n >= 5 && n <= 10) gap_tick = 1'b1;
            end
            if (n == 4)  en = 1'b0;
            if (n == 11) en = 1'b1;
            step();
            n++;
        end
        tests++;
        if (n !== 19 || m_done !== 4'b0001) begin
            fails++;
            $display("FAIL en_done: cycle=%0d done=%b, expected 19/0001", n, m_done);
        end
        tests++;
        if (first_tick !== 13 || gap_tick !== 1'b0 || ticks !== 2) begin
            fails++;
            $display("FAIL en_hold: first tick=%0d gap tick=%b ticks=%0d, expected 13/0/2", first_tick, gap_tick, ticks);
        end
        req = 4'b0000;
        en = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_run();
        int n;
        sel1 = 1'b0;
        do_reset();
        // Serve requester 2 first so ptr is advanced before the reset
        dly = 32'd0;
        req = 4'b0100;
        step();
        step();
        req = 4'b0000;
        step();
        dly[15:8] = 8'd10;
        req = 4'b0010;
        for (n = 0; n < 28; n++) step();
        rst = 1'b1;
        #1;
        tests++;
        if (m_gnt !== 4'b0000 || m_busy !== 1'b0 || m_done !== 4'b0000) begin
            fails++;
            $display("FAIL rst_async: gnt=%b busy=%b done=%b, expected 0000/0/0000", m_gnt, m_busy, m_done);
        end
        req = 4'b1111;
        @(negedge clk);
        step();
        rst = 1'b0;
        step();
        tests++;
        if (m_gnt !== 4'b0001) begin
            fails++;
            $display("FAIL rst_ptr: gnt=%b, expected 0001", m_gnt);
        end
        rst = 1'b1;
        req = 4'b0010;
        step();
        rst = 1'b0;
        step();
        tests++;
        if (m_gnt !== 4'b0010) begin
            fails++;
            $display("FAIL rst_regrant: gnt=%b, expected 0010", m_gnt);
        end
        req = 4'b0000;
    endtask

    task automatic test_withdraw_max();
        int n;
        logic [3:0] gnt_before;
        sel1 = 1'b1;
        do_reset();
        dly[31:24] = 8'd255;
        req = 4'b1000;
        n = 0;
        gnt_before = 4'b0000;
        while (m_done === 4'b0000 && n < 300) begin
            if (n == 5) req = 4'b0000;
            gnt_before = m_gnt;
            step();
            n++;
        end
        tests++;
        if (n !== 257 || m_done !== 4'b1000) begin
            fails++;
            $display("FAIL withdraw_done: cycle=%0d done=%b, expected 257/1000", n, m_done);
        end
        tests++;
        if (gnt_before !== 4'b1000) begin
            fails++;
            $display("FAIL withdraw_gnt: gnt before done=%b, expected 1000", gnt_before);
        end
        step();
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        req  = 4'b0000;
        dly  = 32'd0;
        sel1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_zero_delay();
        test_round_robin();
        test_back_to_back();
        test_enable_gating();
        test_reset_mid_run();
        test_withdraw_max();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_arb.md
Name: timer_arb

Overview:
- Shares one prescaled timer among NREQ requesters. Each requester asks for a delay of D prescaled ticks.
- A round-robin arbiter grants the timer to one requester at a time, loads its delay and counts it down. It then pulses that requester's done line.
- Sits between the slow-event consumers (debouncers, display refresh, blink logic) and the system clock. It replaces per-consumer dividers.

Parameters:
- NREQ, 4, number of requesters (≥2).
- DLY_W, 8, width of each requester's delay value.
- PRESC, 5, system clocks per timer tick (≥1). PRESC=1 means a tick on every RUN cycle.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  prescaler enable. Low freezes the prescaler and the countdown. Arbitration continues.
- req  in  NREQ  per-requester request level.
- dly  in  NREQ*DLY_W  delay for requester i, in bits [i*DLY_W +: DLY_W]. Sampled only in LOAD.
- gnt  out  NREQ  one-hot owner of the timer; all zero when idle.
- done  out  NREQ  one-hot, one-cycle completion pulse to the owner.
- busy  out  1  high whenever state != IDLE.
- tick  out  1  one-cycle prescaler tick, for observation and debug.

Behaviour:
- Reset (async, any time, including mid-RUN):
  - state=IDLE, ptr=0, owner index=0, remaining=0, prescaler count=0.
  - gnt=0, done=0, busy=0, tick=0.
- FSM states: IDLE, LOAD, RUN, DONE. All outputs are registered.
- IDLE:
  - If req != 0, select the first set bit searching from ptr upward, wrapping modulo NREQ. Latch its index and go to LOAD.
  - If req == 0, stay in IDLE.
- LOAD (1 cycle):
  - gnt[idx]=1.
  - remaining <= dly[idx]; prescaler count <= 0.
  - If dly[idx]==0, go to DONE; otherwise go to RUN.
- RUN:
  - gnt[idx]=1.
  - When en=1, the prescaler counts 0..PRESC-1. tick=1 in the cycle where count==PRESC-1 and en=1; count then wraps to 0.
  - On each tick, remaining decrements.
  - A tick with remaining==1 moves the FSM to DONE.
  - tick is forced 0 outside RUN.
- DONE (1 cycle):
  - done[idx]=1, gnt=0.
  - ptr <= (idx+1) mod NREQ.
  - Next state is IDLE.
- Latency: a request sampled in IDLE at cycle t gives done high in cycle t + D*PRESC + 2, with en held high. This holds for D=0 as well (done at t+2).
- en low during RUN stretches the latency by exactly the number of low cycles. The prescaler count is held, not cleared.
- Request withdrawn during LOAD or RUN: ignored. The timer completes and done still pulses; the requester discards it.
- The DONE cycle never grants. A requester that keeps req high is re-arbitrated in the following IDLE cycle, behind the others, because ptr has advanced.
- Back-to-back service: the minimum gap between done pulses is 3 cycles (IDLE, LOAD, DONE with D=0).
- Maximum delay is D=2^DLY_W-1, with no wrap. remaining never underflows because D=0 bypasses RUN.
- Widths:
  - ptr and idx: $clog2(NREQ) bits, wrapped explicitly when NREQ is not a power of 2.
  - Prescaler count: $clog2(PRESC) bits; PRESC=1 uses a 1-bit counter with tick=en.

Decomposition:
- Shared package `timer_pkg`:
  - FSM state encoding localparams (2 bits).
  - Width helper constants: IDX_W = $clog2(NREQ), PC_W = max(1, $clog2(PRESC)).
- One sub-module `tick_gen`:
  - Ports: clk, rst, en, clr (synchronous clear), tick (pulse).
  - Parameter PRESC.
  - Instantiated once; clr is driven in LOAD.
- The round-robin priority search stays inline as a combinational loop.

Test Plan:
- Single request: NREQ=4, PRESC=5, req=0001, dly0=3, en=1 → gnt=0001 from t+1; done=0001 exactly at t+17; busy falls at t+18.
- Zero delay: req=0100, dly2=0 → gnt=0100 at t+1, done=0100 at t+2, no tick ever asserted.
- Round-robin fairness: req=1111 held, all dly=1, PRESC=1 → done order 0,1,2,3,0 with no requester served twice before the others.
- Enable gating: dly=2, PRESC=5, en dropped for 7 cycles mid-RUN → done at t+12+7=t+19; prescaler count unchanged across the gap.
- Reset mid-operation: rst pulsed during RUN with remaining=5 → gnt=0, busy=0, done=0 immediately (asynchronous). After release with req=0010, arbitration starts from ptr=0 and grants requester 1.
- Withdrawal and maximum delay: requester 3 drops req during RUN with dly=255, PRESC=1 → done=1000 still at t+257.
